// File: rtl/spi_reg_peripheral.sv
// Write-only SPI (mode 0) register block: synchronizes the asynchronous SPI pins into clk,
// assembles 16-bit frames and commits valid writes to five 8-bit PWM control registers.
module spi_reg_peripheral #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err
);

    typedef enum logic [1:0] {IDLE, RECV, COMMIT} state_t;

    localparam logic [6:0] MaxAddr = 7'(MAX_ADDR);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclkSync_q, copiSync_q, ncsSync_q;
    logic                   sclkPrev_q, ncsPrev_q;
    logic [15:0]            shift_q, shift_d;
    logic [4:0]             count_q, count_d;
    logic [7:0]             enOutLo_q, enOutHi_q, enPwmLo_q, enPwmHi_q, duty_q;

    logic sclkS, copiS, ncsS;
    logic sclkRise, ncsFall, ncsRise;
    logic frameWrite, frameRead;

    assign sclkS    = sclkSync_q[SYNC_STAGES-1];
    assign copiS    = copiSync_q[SYNC_STAGES-1];
    assign ncsS     = ncsSync_q[SYNC_STAGES-1];
    assign sclkRise = sclkS & ~sclkPrev_q;
    assign ncsFall  = ~ncsS & ncsPrev_q;
    assign ncsRise  = ncsS & ~ncsPrev_q;

    // Only an exact 16-bit count qualifies; the saturating counter keeps long frames from wrapping to 16.
    assign frameWrite = (count_q == 5'd16) && shift_q[15] && (shift_q[14:8] <= MaxAddr);
    assign frameRead  = (count_q == 5'd16) && !shift_q[15];

    always_ff @(posedge clk) begin
        if (rst) begin
            sclkSync_q <= '0;
            copiSync_q <= '0;
            ncsSync_q  <= '1;
            sclkPrev_q <= 1'b0;
            ncsPrev_q  <= 1'b1;
            state_q    <= IDLE;
            shift_q    <= '0;
            count_q    <= '0;
        end else begin
            sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], sclk};
            copiSync_q <= {copiSync_q[SYNC_STAGES-2:0], copi};
            ncsSync_q  <= {ncsSync_q[SYNC_STAGES-2:0], ncs};
            sclkPrev_q <= sclkS;
            ncsPrev_q  <= ncsS;
            state_q    <= state_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        count_d   = count_q;
        wr_strobe = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (ncsFall) begin
                    count_d = '0;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (sclkRise) begin
                    shift_d = {shift_q[14:0], copiS};
                    if (count_q != 5'd31) count_d = count_q + 5'd1;
                end
                if (ncsRise) state_d = COMMIT;
            end
            COMMIT: begin
                state_d = IDLE;
                if (frameWrite) wr_strobe = 1'b1;
                else if (!frameRead) frame_err = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enOutLo_q <= '0;
            enOutHi_q <= '0;
            enPwmLo_q <= '0;
            enPwmHi_q <= '0;
            duty_q    <= '0;
        end else if (wr_strobe) begin
            case (shift_q[14:8])
                7'd0:    enOutLo_q <= shift_q[7:0];
                7'd1:    enOutHi_q <= shift_q[7:0];
                7'd2:    enPwmLo_q <= shift_q[7:0];
                7'd3:    enPwmHi_q <= shift_q[7:0];
                7'd4:    duty_q    <= shift_q[7:0];
                default: ;
            endcase
        end
    end

    assign en_reg_out_7_0  = enOutLo_q;
    assign en_reg_out_15_8 = enOutHi_q;
    assign en_reg_pwm_7_0  = enPwmLo_q;
    assign en_reg_pwm_15_8 = enPwmHi_q;
    assign pwm_duty_cycle  = duty_q;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Bench for spi_reg_peripheral: directed and random SPI frames checked against a
// register-array model of the write rules, plus counts of strobe and error pulses.
module tb_spi_reg_peripheral;

    logic       clk, rst, sclk, copi, ncs;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       wr_strobe, frame_err;

    int vectors = 0;
    int miscompares = 0;
    int strobeCount = 0;
    int errCount = 0;
    int expStrobe = 0;
    int expErr = 0;
    logic [7:0] expRegs [5];

    spi_reg_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters let each frame be judged by how many strobes/errors it produced.
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) strobeCount++;
        if (frame_err === 1'b1) errCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkRegs(input string tag);
        checkOutput({tag, " reg0"}, {24'd0, en_reg_out_7_0}, {24'd0, expRegs[0]});
        checkOutput({tag, " reg1"}, {24'd0, en_reg_out_15_8}, {24'd0, expRegs[1]});
        checkOutput({tag, " reg2"}, {24'd0, en_reg_pwm_7_0}, {24'd0, expRegs[2]});
        checkOutput({tag, " reg3"}, {24'd0, en_reg_pwm_15_8}, {24'd0, expRegs[3]});
        checkOutput({tag, " reg4"}, {24'd0, pwm_duty_cycle}, {24'd0, expRegs[4]});
        checkOutput({tag, " strobes"}, strobeCount, expStrobe);
        checkOutput({tag, " errors"}, errCount, expErr);
    endtask

    // Shifts nbits of 'bits' MSB first; nCS is left low afterwards when useCs is set.
    task automatic applyStimulus(input logic [63:0] bits, input int nbits, input bit useCs);
        @(negedge clk);
        if (useCs) ncs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = bits[i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic endFrame(input int gap);
        ncs = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Reference rule: exactly 16 bits, write bit set and address 0..4 stores; any read
    // of 16 bits is silent; everything else is an error.
    task automatic modelFrame(input logic [15:0] frame, input int nbits);
        if (nbits == 16 && frame[15] && frame[14:8] <= 7'd4) begin
            expRegs[frame[10:8]] = frame[7:0];
            expStrobe++;
        end else if (!(nbits == 16 && !frame[15])) begin
            expErr++;
        end
    endtask

    task automatic writeFrame(input logic [15:0] frame, input string tag);
        applyStimulus({48'd0, frame}, 16, 1'b1);
        endFrame(8);
        modelFrame(frame, 16);
        checkRegs(tag);
    endtask

    initial begin
        logic [15:0] frame;
        logic [63:0] longBits;
        int          nbits;
        int          savedStrobe;

        rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
        for (int i = 0; i < 5; i++) expRegs[i] = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset wr_strobe", {31'd0, wr_strobe}, 32'd0);
        checkOutput("reset frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkRegs("reset");

        // Latency: strobe in the 3rd cycle after nCS rises, register visible in the 4th.
        applyStimulus({48'd0, 16'h8480}, 16, 1'b1);
        ncs = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("latency duty early", {24'd0, pwm_duty_cycle}, 32'h00);
        checkOutput("latency strobe", {31'd0, wr_strobe}, 32'd1);
        @(negedge clk);
        checkOutput("latency duty", {24'd0, pwm_duty_cycle}, 32'h80);
        repeat (4) @(negedge clk);
        modelFrame(16'h8480, 16);
        checkRegs("first write");

        writeFrame(16'h80FF, "w0");
        writeFrame(16'h81F0, "w1");
        writeFrame(16'h8255, "w2");
        writeFrame(16'h83AA, "w3");
        writeFrame(16'h8401, "w4");
        writeFrame(16'h8401, "rewrite");

        writeFrame(16'h8512, "bad addr");
        writeFrame(16'h0012, "read frame");

        applyStimulus({49'd0, 15'h4009}, 15, 1'b1);
        endFrame(8);
        modelFrame(16'h0000, 15);
        checkRegs("15-bit");

        applyStimulus({47'd0, 17'h10177}, 17, 1'b1);
        endFrame(8);
        modelFrame(16'h0177, 17);
        checkRegs("17-bit");

        // 48 bits would wrap a non-saturating 5-bit counter back to 16.
        longBits = 64'h0000_1234_5678_8077;
        applyStimulus(longBits, 48, 1'b1);
        endFrame(8);
        modelFrame(16'h8077, 48);
        checkRegs("48-bit");

        applyStimulus({48'd0, 16'h80FF}, 16, 1'b0);
        endFrame(8);
        checkRegs("no cs");

        // Back-to-back frames with the minimum legal nCS high time.
        applyStimulus({48'd0, 16'h8011}, 16, 1'b1);
        endFrame(3);
        applyStimulus({48'd0, 16'h8122}, 16, 1'b1);
        endFrame(8);
        modelFrame(16'h8011, 16);
        modelFrame(16'h8122, 16);
        checkRegs("back-to-back");

        for (int n = 0; n < 20; n++) begin
            frame = {$urandom_range(0, 3) != 0 ? 1'b1 : 1'b0, 7'($urandom_range(0, 7)), 8'($urandom)};
            case ($urandom_range(0, 5))
                0:       nbits = 15;
                1:       nbits = 17;
                default: nbits = 16;
            endcase
            if (nbits == 15) applyStimulus({49'd0, frame[15:1]}, 15, 1'b1);
            else if (nbits == 17) applyStimulus({47'd0, 1'b1, frame}, 17, 1'b1);
            else applyStimulus({48'd0, frame}, 16, 1'b1);
            endFrame(8);
            modelFrame(frame, nbits);
            checkRegs($sformatf("random %0d", n));
        end

        // Reset mid-frame: partial frame must never commit; error pulses are not judged here.
        savedStrobe = strobeCount;
        applyStimulus({56'd0, 8'h80}, 8, 1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        endFrame(8);
        for (int i = 0; i < 5; i++) expRegs[i] = 8'h00;
        checkOutput("midreset reg0", {24'd0, en_reg_out_7_0}, 32'h00);
        checkOutput("midreset reg4", {24'd0, pwm_duty_cycle}, 32'h00);
        checkOutput("midreset strobes", strobeCount, savedStrobe);

        applyStimulus({48'd0, 16'h8033}, 16, 1'b1);
        endFrame(8);
        checkOutput("post reset reg0", {24'd0, en_reg_out_7_0}, 32'h33);
        checkOutput("post reset strobes", strobeCount, savedStrobe + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
